// File: rtl/sum_n.sv
// Moving-window signed adder: out is the sum of the last TAPS accepted samples,
// kept as a running accumulator. Optional output clamping via SUM_N_SAT_EN.
module sum_n #(
    parameter int WIDTH     = 8,
    parameter int TAPS      = 3,
    parameter int OUT_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic        [WIDTH-1:0]     in,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    output logic                        sat
);

    localparam int ACC_W  = WIDTH + $clog2(TAPS);
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

    if (TAPS < 2) begin : g_bad_taps
        $error("sum_n: TAPS must be at least 2");
    end
    if (OUT_WIDTH < WIDTH) begin : g_bad_out_width
        $error("sum_n: OUT_WIDTH must be at least WIDTH");
    end

    logic signed [WIDTH-1:0]     line_r [TAPS];
    logic signed [ACC_W-1:0]     acc_r;
    logic signed [ACC_W-1:0]     acc_nxt_s;
    logic signed [ACC_W-1:0]     in_ext_s;
    logic signed [ACC_W-1:0]     old_ext_s;
    logic        [FILL_W-1:0]    fill_r;
    logic        [FILL_W-1:0]    fill_nxt_s;
    logic signed [OUT_WIDTH-1:0] out_r;
    logic signed [OUT_WIDTH-1:0] out_nxt_s;
    logic                        valid_r;
    logic                        sat_r;
    logic                        ovf_s;

    assign in_ext_s  = {{(ACC_W-WIDTH){in[WIDTH-1]}}, in};
    assign old_ext_s = {{(ACC_W-WIDTH){line_r[TAPS-1][WIDTH-1]}}, line_r[TAPS-1]};

    // Next accumulator and saturating fill count for an accepted sample
    always_comb begin
        acc_nxt_s  = acc_r + in_ext_s - old_ext_s;
        fill_nxt_s = fill_r;
        if (fill_r == FILL_FULL) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FILL_W'(1);
        end
    end

    if (OUT_WIDTH >= ACC_W) begin : g_wide
        // Output is wide enough: plain sign extension, never overflows
        always_comb begin
            out_nxt_s = OUT_WIDTH'(acc_nxt_s);
            ovf_s     = 1'b0;
        end
    end else begin : g_narrow
`ifdef SUM_N_SAT_EN
        localparam logic signed [ACC_W-1:0] OUT_HI =
            {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] OUT_LO =
            {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

        // Clamp the accumulator into the output range and flag when clamped
        always_comb begin
            out_nxt_s = OUT_WIDTH'(acc_nxt_s);
            ovf_s     = 1'b0;
            if (acc_nxt_s > OUT_HI) begin
                out_nxt_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                ovf_s     = 1'b1;
            end else if (acc_nxt_s < OUT_LO) begin
                out_nxt_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                ovf_s     = 1'b1;
            end else begin
                out_nxt_s = OUT_WIDTH'(acc_nxt_s);
                ovf_s     = 1'b0;
            end
        end
`else
        // Keep the low bits only; the accumulator itself stays exact
        always_comb begin
            out_nxt_s = OUT_WIDTH'(acc_nxt_s);
            ovf_s     = 1'b0;
        end
`endif
    end

    // Delay line, accumulator, fill count and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                line_r[k] <= '0;
            end
            acc_r   <= '0;
            fill_r  <= '0;
            out_r   <= '0;
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) begin
                line_r[k] <= '0;
            end
            acc_r   <= '0;
            fill_r  <= '0;
            out_r   <= '0;
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
        end else if (en) begin
            line_r[0] <= in;
            for (int k = 1; k < TAPS; k++) begin
                line_r[k] <= line_r[k-1];
            end
            acc_r   <= acc_nxt_s;
            fill_r  <= fill_nxt_s;
            out_r   <= out_nxt_s;
            valid_r <= (fill_nxt_s == FILL_FULL);
            sat_r   <= ovf_s;
        end
    end

    assign out       = out_r;
    assign out_valid = valid_r;
    assign sat       = sat_r;

endmodule
